// File: rtl/pc_unit.sv
// Purpose: fetch-stage program counter with prioritised redirect, stall, misalign trap and optional RAS (macro PC_RAS_EN).
// Latency: next PC is combinational from pc and inputs; pc/epc/misalign_err update 1 cycle later; pc_plus_step same cycle.
// Backpressure: pc_write=0 stalls pc, epc and RAS; trap_en overrides a stall; reset_n low clears state asynchronously.
module pc_unit #(
    parameter int          WIDTH        = 32,
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080,
    parameter int          STEP         = 4,
    parameter int          ALIGN_BITS   = 2,
    parameter int          RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pc_write,
    input  logic             trap_en,
    input  logic             jump_en,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    input  logic             call_en,
    input  logic             ret_en,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus_step,
    output logic [WIDTH-1:0] epc,
    output logic             misalign_err,
    output logic             ras_empty
);

    localparam logic [WIDTH-1:0] RST_PC  = WIDTH'(RESET_VECTOR);
    localparam logic [WIDTH-1:0] TRAP_PC = WIDTH'(TRAP_VECTOR);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             misalign_q, misalign_d;

    // RAS handshake into the core selection logic
    logic             ret_take;    // return redirect actually taken this cycle
    logic             jump_sel;    // jump_target is the selected source
    logic [WIDTH-1:0] ras_top;
    logic             push;
    logic             pop;

    // Sequential step wraps naturally at the PC width
    assign pc_plus_step = pc_q + WIDTH'(STEP);
    assign pc           = pc_q;
    assign epc          = epc_q;
    assign misalign_err = misalign_q;

`ifdef PC_RAS_EN
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] ras_q [RAS_DEPTH];
    logic [WIDTH-1:0] ras_d [RAS_DEPTH];
    logic [PTR_W-1:0] ptr_q, ptr_d;   // next slot to write; top is ptr_q-1
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0] top_idx;

    assign top_idx   = ptr_q - 1'b1;
    assign ras_top   = ras_q[top_idx];
    assign ras_empty = (cnt_q == '0);
    assign ret_take  = ret_en && !ras_empty;
    assign jump_sel  = jump_en;

    // RAS next state: circular push overwrites oldest, count saturates at depth
    always_comb begin
        ras_d = ras_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (pop) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - 1'b1;
        end else if (push) begin
            ras_d[ptr_q] = pc_plus_step;
            ptr_d        = ptr_q + 1'b1;
            if (cnt_q != CNT_W'(RAS_DEPTH)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // RAS storage and pointer registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ras_q <= ras_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end
`else
    // Without a RAS a return is just another jump through jump_target
    logic unused_ras;
    assign unused_ras = call_en ^ push ^ pop;
    assign ras_top    = '0;
    assign ras_empty  = 1'b1;
    assign ret_take   = 1'b0;
    assign jump_sel   = jump_en || ret_en;
`endif

    // Next-PC selection: trap > return > jump > branch > sequential
    always_comb begin
        logic             redirect;
        logic [WIDTH-1:0] target;
        pc_d       = pc_q;
        epc_d      = epc_q;
        misalign_d = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        redirect   = 1'b0;
        target     = '0;
        if (trap_en) begin
            pc_d  = TRAP_PC;
            epc_d = pc_q;
        end else if (pc_write) begin
            if (ret_take) begin
                pc_d = ras_top;
                pop  = 1'b1;
            end else if (jump_sel) begin
                redirect = 1'b1;
                target   = jump_target;
            end else if (branch_taken) begin
                redirect = 1'b1;
                target   = branch_target;
            end else begin
                pc_d = pc_plus_step;
            end
            if (redirect) begin
                if (target[ALIGN_BITS-1:0] != '0) begin
                    // Misaligned redirect traps and leaves the RAS alone
                    pc_d       = TRAP_PC;
                    epc_d      = pc_q;
                    misalign_d = 1'b1;
                end else begin
                    pc_d = target;
                    push = call_en && jump_en;
                end
            end
        end
    end

    // PC, fault PC and misalign pulse registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= RST_PC;
            epc_q      <= '0;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            epc_q      <= epc_d;
            misalign_q <= misalign_d;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset, stepping, stall, priority, trap, misalign, wrap and RAS behaviour.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Summary line reports total comparisons and failures.
module tb_pc_unit;

    logic        clk;
    logic        reset_n;
    logic        pc_write;
    logic        trap_en;
    logic        jump_en;
    logic [31:0] jump_target;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        call_en;
    logic        ret_en;
    logic [31:0] pc;
    logic [31:0] pc_plus_step;
    logic [31:0] epc;
    logic        misalign_err;
    logic        ras_empty;

    int total = 0;
    int bad   = 0;

    pc_unit dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .pc_write      (pc_write),
        .trap_en       (trap_en),
        .jump_en       (jump_en),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .call_en       (call_en),
        .ret_en        (ret_en),
        .pc            (pc),
        .pc_plus_step  (pc_plus_step),
        .epc           (epc),
        .misalign_err  (misalign_err),
        .ras_empty     (ras_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        trap_en      = 1'b0;
        jump_en      = 1'b0;
        branch_taken = 1'b0;
        call_en      = 1'b0;
        ret_en       = 1'b0;
    endtask

    initial begin
        reset_n       = 1'b0;
        pc_write      = 1'b0;
        jump_target   = '0;
        branch_target = '0;
        idle();

        // Reset state
        #3;
        chk("rst_pc", pc, 32'h0);
        chk("rst_epc", epc, 32'h0);
        chk("rst_mis", 32'(misalign_err), 32'h0);
        chk("rst_ras_empty", 32'(ras_empty), 32'h1);
        chk("rst_pc_plus_step", pc_plus_step, 32'h4);
        #4;
        reset_n  = 1'b1;
        pc_write = 1'b1;

        // Sequential stepping
        step(); chk("seq_4", pc, 32'h4);
        step(); chk("seq_8", pc, 32'h8);
        step(); chk("seq_c", pc, 32'hC);

        // Asynchronous reset mid-cycle
        #2; reset_n = 1'b0;
        #1; chk("async_rst_pc", pc, 32'h0);
        #1; reset_n = 1'b1;
        step(); step(); step(); step();
        chk("seq_after_rst", pc, 32'h10);

        // Stall holds a pending branch; releasing the stall takes it
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        pc_write      = 1'b0;
        step(); chk("stall_hold", pc, 32'h10);
        step(); chk("stall_hold2", pc, 32'h10);
        pc_write = 1'b1;
        step(); chk("branch_taken", pc, 32'h40);

        // Jump beats branch
        jump_en       = 1'b1;
        jump_target   = 32'h100;
        branch_target = 32'h200;
        step(); chk("jump_over_branch", pc, 32'h100);

        // Trap beats everything and overrides a stall
        trap_en  = 1'b1;
        pc_write = 1'b0;
        step();
        chk("trap_pc", pc, 32'h80);
        chk("trap_epc", epc, 32'h100);
        chk("trap_no_mis", 32'(misalign_err), 32'h0);
        idle();
        pc_write = 1'b1;

        // Misaligned jump at pc 0x20
        jump_en     = 1'b1;
        jump_target = 32'h20;
        step(); chk("jump_20", pc, 32'h20);
        jump_target = 32'h102;
        step();
        chk("mis_pc", pc, 32'h80);
        chk("mis_epc", epc, 32'h20);
        chk("mis_pulse", 32'(misalign_err), 32'h1);
        idle();
        step();
        chk("mis_clear", 32'(misalign_err), 32'h0);
        chk("mis_after_seq", pc, 32'h84);
        chk("mis_epc_hold", epc, 32'h20);

        // Misaligned branch target also traps
        branch_taken  = 1'b1;
        branch_target = 32'h43;
        step();
        chk("bmis_pc", pc, 32'h80);
        chk("bmis_epc", epc, 32'h84);
        chk("bmis_pulse", 32'(misalign_err), 32'h1);
        idle();

        // Wrap at the top of the address space
        jump_en     = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        step();
        chk("wrap_pre", pc, 32'hFFFF_FFFC);
        chk("wrap_pps", pc_plus_step, 32'h0);
        idle();
        step(); chk("wrap_pc", pc, 32'h0);

`ifdef PC_RAS_EN
        // Five calls into a 4-deep RAS, then unwind
        #2; reset_n = 1'b0;
        #1; reset_n = 1'b1;
        #2;
        for (int i = 0; i < 5; i++) begin
            jump_en     = 1'b1;
            call_en     = 1'b1;
            jump_target = 32'((i + 1) * 16);
            step();
        end
        chk("ras_call_pc", pc, 32'h50);
        chk("ras_not_empty", 32'(ras_empty), 32'h0);
        idle();
        ret_en = 1'b1;
        step(); chk("ret_1", pc, 32'h44);
        step(); chk("ret_2", pc, 32'h34);
        step(); chk("ret_3", pc, 32'h24);
        step(); chk("ret_4", pc, 32'h14);
        chk("ras_empty_after", 32'(ras_empty), 32'h1);
        step(); chk("ret_fallthrough", pc, 32'h18);
        chk("ras_still_empty", 32'(ras_empty), 32'h1);
        idle();
`else
        // Without a RAS, return uses jump_target and calls do not fill anything
        ret_en      = 1'b1;
        jump_target = 32'h300;
        step();
        chk("ret_as_jump", pc, 32'h300);
        chk("ret_ras_empty", 32'(ras_empty), 32'h1);
        ret_en  = 1'b0;
        jump_en = 1'b1;
        call_en = 1'b1;
        jump_target = 32'h400;
        step();
        chk("call_jump", pc, 32'h400);
        chk("call_ras_empty", 32'(ras_empty), 32'h1);
        idle();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the CPU fetch stage. It replaces the plain PC register with:
- prioritised next-PC selection (trap, jump, branch, sequential);
- stall control;
- misaligned-target trapping with a captured fault PC;
- an optional return-address stack (RAS).

It drives the instruction-memory address and supplies `pc_plus_step` to the link-register writeback path.

## Interface
Parameters:
- `WIDTH`, 32: PC width in bits.
- `RESET_VECTOR`, 32'h0000_0000: PC value after reset.
- `TRAP_VECTOR`, 32'h0000_0080: PC loaded on a trap or a misaligned target.
- `STEP`, 4: sequential increment in bytes.
- `ALIGN_BITS`, 2: low target bits that must be zero.
- `RAS_DEPTH`, 4: RAS entries, power of two, ≥2. Used only with `PC_RAS_EN`.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pc_write`  in  1  1 = PC may advance this cycle; 0 = hold (stall).
- `trap_en`  in  1  external exception request.
- `jump_en`  in  1  unconditional jump to `jump_target`.
- `jump_target`  in  WIDTH  jump destination.
- `branch_taken`  in  1  resolved taken branch.
- `branch_target`  in  WIDTH  branch destination.
- `call_en`  in  1  current jump is a call: push the return address.
- `ret_en`  in  1  return: pop the RAS for the target.
- `pc`  out  WIDTH  current PC (registered).
- `pc_plus_step`  out  WIDTH  `pc + STEP`, combinational.
- `epc`  out  WIDTH  PC at the last trap or misalign event (registered).
- `misalign_err`  out  1  one-cycle pulse after a misaligned redirect.
- `ras_empty`  out  1  RAS holds no valid entries.

## Operation
- Reset values: `pc` = `RESET_VECTOR`, `epc` = 0, `misalign_err` = 0, RAS count = 0, `ras_empty` = 1.
- Next-PC priority, evaluated every cycle:
  1. `trap_en`: load `TRAP_VECTOR`.
  2. `ret_en` (RAS built): load the RAS top.
  3. `jump_en`: load `jump_target`.
  4. `branch_taken`: load `branch_target`.
  5. Otherwise: load `pc_plus_step`.
- `trap_en` acts even when `pc_write` = 0 (a flush overrides a stall). All other sources act only when `pc_write` = 1.
- Misalignment check on a selected jump or branch target:
  - Condition: any of the low `ALIGN_BITS` bits is nonzero.
  - PC loads `TRAP_VECTOR`, `epc` captures the current `pc`, and `misalign_err` = 1 on the following cycle.
  - The RAS is unchanged.
- On `trap_en`, `epc` captures the current `pc`. `misalign_err` stays 0.
- Arithmetic: `pc + STEP` wraps modulo 2^WIDTH. No carry-out.
- RAS rules:
  - `call_en` with `jump_en` pushes `pc_plus_step`. `call_en` without `jump_en` is ignored.
  - Push when full overwrites the oldest entry (circular pointer). Count saturates at `RAS_DEPTH`.
  - `ret_en` when empty: the next PC falls through to the lower priorities. No pop, no error.
  - `call_en` and `ret_en` together: the return is taken. There is no push, so the pop wins.
  - `trap_en` does not touch the RAS.

## Timing
- `pc` updates on the rising `clk` edge. The next PC is a combinational function of `pc` and the inputs in the same cycle, so redirect latency is 1 cycle.
- `pc_plus_step` is valid in the same cycle as `pc`.
- `misalign_err` and `epc` are valid the cycle after the offending edge. `misalign_err` clears on the next edge unless the event repeats.
- `reset_n` low forces all reset values immediately, at any time and regardless of `clk`. This includes mid-stall and mid-RAS-push. After release, the first update is on the first rising edge with `reset_n` high.
- Stall: while `pc_write` = 0 and `trap_en` = 0, `pc`, `epc` and the RAS hold.

## Configuration
- Macro: `PC_RAS_EN`.
- Defined: RAS storage and pointers are instantiated. `ret_en` selects the RAS top and `ras_empty` reflects the count.
- Undefined: no RAS storage. `call_en` is ignored. `ret_en` behaves as `jump_en`, i.e. the target comes from `jump_target`. `ras_empty` is tied to 1.

## Test plan
- Reset then 3 cycles with `pc_write` = 1 → `pc` = 0, 4, 8, 12. Assert `reset_n` = 0 mid-cycle → `pc` = 0 immediately.
- `pc` = 0x10, `branch_taken` = 1, target 0x40, `pc_write` = 0 → `pc` stays 0x10. Raise `pc_write` → `pc` = 0x40 next edge.
- `jump_en` and `branch_taken` together, targets 0x100 and 0x200 → `pc` = 0x100. Add `trap_en` → `pc` = 0x80 and `epc` = old `pc`, even with `pc_write` = 0.
- `jump_target` = 0x102 at `pc` = 0x20 → `pc` = 0x80, `epc` = 0x20, `misalign_err` high for exactly 1 cycle.
- `PC_RAS_EN`, `RAS_DEPTH` = 4:
  - Calls from 0x0, 0x10, 0x20, 0x30, 0x40 → returns yield 0x44, 0x34, 0x24, 0x14, in that order.
  - A fifth `ret_en` yields the priority fall-through and `ras_empty` = 1.
- `pc` = 0xFFFF_FFFC, sequential step → `pc` = 0x0000_0000.
